// File: rtl/stream_sort_engine.sv
// Streaming frame sorter: receives a frame, bubble-sorts it in place with one compare-exchange per cycle,
// then streams it back out. Define SORT_DUP_COUNT_EN to enable duplicate counting (dup_nums tied to 0 otherwise).
module stream_sort_engine #(
  parameter int ELEM_WIDTH = 16,
  parameter int LANES      = 2,
  parameter int DEPTH      = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ELEM_WIDTH*LANES-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic [ELEM_WIDTH*LANES-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  input  logic                        sort_dir,
  output logic [15:0]                 dup_nums,
  output logic                        overflow,
  output logic                        busy
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int BEATS = DEPTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {RECV, SORT, SEND} state_t;
  state_t state, state_n;

  logic [ELEM_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         count;
  logic                  dir;
  logic [AW-1:0]         j, lim;
  logic                  swapped;
  logic [BW-1:0]         beat;

  logic                  s_accept, room, recv_done, short_frame;
  logic [CW-1:0]         count_after;
  logic [ELEM_WIDTH-1:0] elem_a, elem_b;
  logic                  do_swap, pass_end, any_swap, sort_done;
  logic                  m_accept, last_beat;

  assign s_axis_tready = (state == RECV);
  assign busy          = (state != RECV);
  assign s_accept      = s_axis_tready && s_axis_tvalid;
  assign room          = (count < CW'(DEPTH));
  assign count_after   = room ? count + CW'(LANES) : count;
  assign recv_done     = s_accept && s_axis_tlast;
  assign short_frame   = (count_after < CW'(2));

  assign elem_a    = mem[j];
  assign elem_b    = mem[j + AW'(1)];
  assign do_swap   = dir ? (elem_a > elem_b) : (elem_a < elem_b);
  assign pass_end  = (j == lim - AW'(1));
  assign any_swap  = swapped || do_swap;
  // A clean pass, or a pass that has shrunk to the first pair, leaves the frame fully ordered.
  assign sort_done = (state == SORT) && pass_end && (!any_swap || lim == AW'(1));

  assign m_axis_tvalid = (state == SEND);
  assign last_beat     = ((CW'(beat) + CW'(1)) * CW'(LANES) == count);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign m_accept      = m_axis_tvalid && m_axis_tready;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    m_axis_tdata = '0;
    if (state == SEND) begin
      for (int k = 0; k < LANES; k++)
        m_axis_tdata[k*ELEM_WIDTH +: ELEM_WIDTH] = mem[AW'(int'(beat) * LANES + k)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RECV;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RECV:    if (recv_done) state_n = short_frame ? SEND : SORT;
      SORT:    if (sort_done) state_n = SEND;
      SEND:    if (m_accept && last_beat) state_n = RECV;
      default: state_n = RECV;
    endcase
  end

  // NOTE: element storage is deliberately not reset; each frame writes every element it later reads.
  always_ff @(posedge clk) begin
    if (s_accept && room) begin
      for (int k = 0; k < LANES; k++)
        mem[AW'(count) + AW'(k)] <= s_axis_tdata[k*ELEM_WIDTH +: ELEM_WIDTH];
    end else if (state == SORT && do_swap) begin
      mem[j]           <= elem_b;
      mem[j + AW'(1)]  <= elem_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      dir      <= 1'b1;
      overflow <= 1'b0;
      j        <= '0;
      lim      <= '0;
      swapped  <= 1'b0;
      beat     <= '0;
    end else begin
      unique case (state)
        RECV: if (s_accept) begin
          count   <= count_after;
          j       <= '0;
          lim     <= AW'(count_after - CW'(1));
          swapped <= 1'b0;
          beat    <= '0;
          if (count == '0) begin
            dir      <= sort_dir;
            overflow <= 1'b0;
          end else if (!room) begin
            overflow <= 1'b1;
          end
        end
        SORT: begin
          if (pass_end) begin
            j       <= '0;
            lim     <= lim - AW'(1);
            swapped <= 1'b0;
          end else begin
            j       <= j + AW'(1);
            swapped <= any_swap;
          end
        end
        SEND: if (m_accept) begin
          if (last_beat) begin
            count <= '0;
            beat  <= '0;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SORT_DUP_COUNT_EN
  // Pairs behind the shrinking pass limit are final; each pass end folds one such pair into tail_dups.
  logic [15:0]           pass_dups, tail_dups, pass_dups_n, tail_dups_n;
  logic [CW-1:0]         tail_idx;
  logic                  tail_valid;
  logic [ELEM_WIDTH-1:0] settled, tail_elem;

  assign tail_idx    = CW'(j) + CW'(2);
  assign tail_valid  = (tail_idx < count);
  assign tail_elem   = mem[tail_valid ? tail_idx[AW-1:0] : '0];
  assign settled     = do_swap ? elem_a : elem_b;
  assign pass_dups_n = pass_dups + 16'(elem_a == elem_b);
  assign tail_dups_n = tail_dups + 16'(pass_end && tail_valid && (settled == tail_elem));

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_dups <= '0;
      tail_dups <= '0;
      dup_nums  <= '0;
    end else begin
      unique case (state)
        RECV: begin
          pass_dups <= '0;
          tail_dups <= '0;
          if (recv_done && short_frame) dup_nums <= '0;
        end
        SORT: begin
          if (sort_done) begin
            dup_nums <= pass_dups_n + tail_dups_n;
          end else if (pass_end) begin
            pass_dups <= '0;
            tail_dups <= tail_dups_n;
          end else begin
            pass_dups <= pass_dups_n;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign dup_nums = '0;
`endif

endmodule
